// File: rtl/rf_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_access_scheduler
// Purpose  : Per-cycle port scheduler for the banked register block. Merges
//            one operand-read requester and two writeback requesters (wb0,
//            wb1) onto two read ports and one write port that share a single
//            warp selector. Returns registered operand data with same-cycle
//            write bypass.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            rd_*_i / rd_ready_o - operand-read request and grant
//            wbN_*_i / wbN_ready_o - writeback requests (N=0,1) and grants
//            rf_*_o / rf_rdata_*_i - register block drive and read data
//            rsp_valid_o, rsp_data0_o, rsp_data1_o - operand response
// Revision : 1.0 - initial release
// ============================================================================
module rf_access_scheduler #(
  parameter  int unsigned NUM_LANES    = 8,
  parameter  int unsigned NUM_WARPS    = 8,
  parameter  int unsigned NUM_REGS     = 32,
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned STARVE_LIMIT = 4,
  localparam int unsigned WW           = $clog2(NUM_WARPS),
  localparam int unsigned AW           = $clog2(NUM_REGS),
  localparam int unsigned DW           = NUM_LANES * DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  // operand read requester
  input  logic                 rd_valid_i,
  output logic                 rd_ready_o,
  input  logic [WW-1:0]        rd_warp_i,
  input  logic [AW-1:0]        rd_addr0_i,
  input  logic [AW-1:0]        rd_addr1_i,
  input  logic [NUM_LANES-1:0] rd_mask_i,
  // writeback requester 0
  input  logic                 wb0_valid_i,
  output logic                 wb0_ready_o,
  input  logic [WW-1:0]        wb0_warp_i,
  input  logic [AW-1:0]        wb0_addr_i,
  input  logic [NUM_LANES-1:0] wb0_mask_i,
  input  logic [DW-1:0]        wb0_data_i,
  // writeback requester 1
  input  logic                 wb1_valid_i,
  output logic                 wb1_ready_o,
  input  logic [WW-1:0]        wb1_warp_i,
  input  logic [AW-1:0]        wb1_addr_i,
  input  logic [NUM_LANES-1:0] wb1_mask_i,
  input  logic [DW-1:0]        wb1_data_i,
  // register block
  output logic [WW-1:0]        rf_warp_selector_o,
  output logic [NUM_LANES-1:0] rf_read_en_0_o,
  output logic [NUM_LANES-1:0] rf_read_en_1_o,
  output logic [AW-1:0]        rf_raddr_0_o,
  output logic [AW-1:0]        rf_raddr_1_o,
  output logic [NUM_LANES-1:0] rf_write_en_o,
  output logic [AW-1:0]        rf_waddr_o,
  output logic [DW-1:0]        rf_wdata_o,
  input  logic [DW-1:0]        rf_rdata_0_i,
  input  logic [DW-1:0]        rf_rdata_1_i,
  // operand response
  output logic                 rsp_valid_o,
  output logic [DW-1:0]        rsp_data0_o,
  output logic [DW-1:0]        rsp_data1_o
);

  // Counter wide enough to hold STARVE_LIMIT (at least one bit).
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          rr_q, rr_d;               // preferred writeback source
  logic [SW-1:0] starve_q, starve_d;       // consecutive write-blocked reads
  logic [WW-1:0] sel_q;                    // last driven warp selector
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data0_q, rsp_data0_d;
  logic [DW-1:0] rsp_data1_q, rsp_data1_d;

  // --------------------------------------------------------------------------
  // Write candidate (round-robin between wb0 and wb1)
  // --------------------------------------------------------------------------
  logic                 w_wr_req;
  logic                 w_wsel;            // 0 = wb0, 1 = wb1
  logic [WW-1:0]        w_wwarp;
  logic [AW-1:0]        w_waddr;
  logic [NUM_LANES-1:0] w_wmask;
  logic [DW-1:0]        w_wdata;

  assign w_wr_req = wb0_valid_i | wb1_valid_i;
  // With a single requester the pointer is ignored.
  assign w_wsel   = (wb0_valid_i & wb1_valid_i) ? rr_q : wb1_valid_i;
  assign w_wwarp  = w_wsel ? wb1_warp_i : wb0_warp_i;
  assign w_waddr  = w_wsel ? wb1_addr_i : wb0_addr_i;
  assign w_wmask  = w_wsel ? wb1_mask_i : wb0_mask_i;
  assign w_wdata  = w_wsel ? wb1_data_i : wb0_data_i;

  // --------------------------------------------------------------------------
  // Grant decision
  // --------------------------------------------------------------------------
  logic w_rd_gnt;
  logic w_wr_gnt;

  always_comb begin
    w_rd_gnt = 1'b0;
    w_wr_gnt = 1'b0;
    if (!rst) begin
      if (rd_valid_i && w_wr_req) begin
        // The shared warp selector only allows pairing on the same warp.
        if (rd_warp_i == w_wwarp) begin
          w_rd_gnt = 1'b1;
          w_wr_gnt = 1'b1;
        end else if (starve_q >= c_starve_max) begin
          w_rd_gnt = 1'b1;
        end else begin
          w_wr_gnt = 1'b1;
        end
      end else begin
        w_rd_gnt = rd_valid_i;
        w_wr_gnt = w_wr_req;
      end
    end
  end

  assign rd_ready_o  = w_rd_gnt;
  assign wb0_ready_o = w_wr_gnt & ~w_wsel;
  assign wb1_ready_o = w_wr_gnt &  w_wsel;

  // --------------------------------------------------------------------------
  // Register block drive
  // --------------------------------------------------------------------------
  assign rf_warp_selector_o = w_rd_gnt ? rd_warp_i :
                              w_wr_gnt ? w_wwarp   : sel_q;
  assign rf_read_en_0_o     = w_rd_gnt ? rd_mask_i : '0;
  assign rf_read_en_1_o     = w_rd_gnt ? rd_mask_i : '0;
  assign rf_raddr_0_o       = rd_addr0_i;
  assign rf_raddr_1_o       = rd_addr1_i;
  assign rf_write_en_o      = w_wr_gnt ? w_wmask   : '0;
  assign rf_waddr_o         = w_waddr;
  assign rf_wdata_o         = w_wdata;

  // --------------------------------------------------------------------------
  // Response lanes: masked-off lanes return 0; a lane being written in the
  // same cycle to the same register returns the new data.
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_rsp0;
  logic [DW-1:0] w_rsp1;
  logic          w_pair;

  // Pairing implies the same warp, so only address and lane must match.
  assign w_pair = w_rd_gnt & w_wr_gnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic w_byp0;
    logic w_byp1;
    assign w_byp0 = w_pair & (rd_addr0_i == w_waddr) & rd_mask_i[i] & w_wmask[i];
    assign w_byp1 = w_pair & (rd_addr1_i == w_waddr) & rd_mask_i[i] & w_wmask[i];
    assign w_rsp0[i*DATA_WIDTH +: DATA_WIDTH] =
      !rd_mask_i[i] ? '0 :
      w_byp0        ? w_wdata[i*DATA_WIDTH +: DATA_WIDTH] :
                      rf_rdata_0_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_rsp1[i*DATA_WIDTH +: DATA_WIDTH] =
      !rd_mask_i[i] ? '0 :
      w_byp1        ? w_wdata[i*DATA_WIDTH +: DATA_WIDTH] :
                      rf_rdata_1_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    rr_d        = rr_q;
    starve_d    = starve_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;

    if (w_wr_gnt) begin
      rr_d = ~w_wsel;
    end

    if (!rd_valid_i || w_rd_gnt) begin
      starve_d = '0;
    end else if (starve_q != c_starve_max) begin
      starve_d = starve_q + 1'b1;
    end

    if (w_rd_gnt) begin
      rsp_data0_d = w_rsp0;
      rsp_data1_d = w_rsp1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      starve_q    <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      sel_q       <= rf_warp_selector_o;
      rsp_valid_q <= w_rd_gnt;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  // An in-flight response is dropped if reset arrives in its cycle.
  assign rsp_valid_o = rsp_valid_q & ~rst;
  assign rsp_data0_o = rsp_data0_q;
  assign rsp_data1_o = rsp_data1_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_access_scheduler
// Purpose  : Self-checking bench for rf_access_scheduler. A register block
//            model answers reads; a behavioural scheduler model predicts
//            grants, port drive and responses every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_access_scheduler;

  localparam int NUM_LANES    = 8;
  localparam int NUM_WARPS    = 8;
  localparam int NUM_REGS     = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int WW           = $clog2(NUM_WARPS);
  localparam int AW           = $clog2(NUM_REGS);
  localparam int DW           = NUM_LANES * DATA_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rd_valid, rd_ready;
  logic [WW-1:0]        rd_warp;
  logic [AW-1:0]        rd_addr0, rd_addr1;
  logic [NUM_LANES-1:0] rd_mask;
  logic                 wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [WW-1:0]        wb0_warp, wb1_warp;
  logic [AW-1:0]        wb0_addr, wb1_addr;
  logic [NUM_LANES-1:0] wb0_mask, wb1_mask;
  logic [DW-1:0]        wb0_data, wb1_data;
  logic [WW-1:0]        rf_warp_selector;
  logic [NUM_LANES-1:0] rf_read_en_0, rf_read_en_1, rf_write_en;
  logic [AW-1:0]        rf_raddr_0, rf_raddr_1, rf_waddr;
  logic [DW-1:0]        rf_wdata, rf_rdata_0, rf_rdata_1;
  logic                 rsp_valid;
  logic [DW-1:0]        rsp_data0, rsp_data1;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  rf_access_scheduler #(
    .NUM_LANES(NUM_LANES), .NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_warp_i(rd_warp),
    .rd_addr0_i(rd_addr0), .rd_addr1_i(rd_addr1), .rd_mask_i(rd_mask),
    .wb0_valid_i(wb0_valid), .wb0_ready_o(wb0_ready), .wb0_warp_i(wb0_warp),
    .wb0_addr_i(wb0_addr), .wb0_mask_i(wb0_mask), .wb0_data_i(wb0_data),
    .wb1_valid_i(wb1_valid), .wb1_ready_o(wb1_ready), .wb1_warp_i(wb1_warp),
    .wb1_addr_i(wb1_addr), .wb1_mask_i(wb1_mask), .wb1_data_i(wb1_data),
    .rf_warp_selector_o(rf_warp_selector),
    .rf_read_en_0_o(rf_read_en_0), .rf_read_en_1_o(rf_read_en_1),
    .rf_raddr_0_o(rf_raddr_0), .rf_raddr_1_o(rf_raddr_1),
    .rf_write_en_o(rf_write_en), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_rdata_0_i(rf_rdata_0), .rf_rdata_1_i(rf_rdata_1),
    .rsp_valid_o(rsp_valid), .rsp_data0_o(rsp_data0), .rsp_data1_o(rsp_data1)
  );

  // Initial register contents, distinct per warp/register/lane.
  function automatic logic [DW-1:0] pat_word(input int w, input int r);
    logic [DW-1:0] v;
    for (int i = 0; i < NUM_LANES; i++)
      v[i*DATA_WIDTH +: DATA_WIDTH] = 32'h5A000000 | 32'(w << 16) | 32'(r << 8) | 32'(i);
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < NUM_LANES; i++) v[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Register block: combinational read, per-lane write at the clock edge.
  // --------------------------------------------------------------------------
  logic [DW-1:0] env_mem [NUM_WARPS][NUM_REGS];
  bit env_ready;

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int w = 0; w < NUM_WARPS; w++)
        for (int r = 0; r < NUM_REGS; r++) env_mem[w][r] <= pat_word(w, r);
      env_ready <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (rf_write_en[i])
          env_mem[rf_warp_selector][rf_waddr][i*DATA_WIDTH +: DATA_WIDTH]
            <= rf_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rf_rdata_0 = env_mem[rf_warp_selector][rf_raddr_0];
  assign rf_rdata_1 = env_mem[rf_warp_selector][rf_raddr_1];

  // --------------------------------------------------------------------------
  // Behavioural model + compare, once per cycle on the falling edge.
  // A response equals the register contents after this cycle's write lands.
  // --------------------------------------------------------------------------
  logic [DW-1:0] ref_mem [NUM_WARPS][NUM_REGS];

  initial begin : p_model
    bit                   rr_m, pend_m, have0, have1, hw, rg, wg, ws;
    int                   starve_m;
    logic [WW-1:0]        last_sel_m, ww, esel;
    logic [AW-1:0]        wa;
    logic [NUM_LANES-1:0] wm;
    logic [DW-1:0]        wd, pend0, pend1, cur0, cur1;

    for (int w = 0; w < NUM_WARPS; w++)
      for (int r = 0; r < NUM_REGS; r++) ref_mem[w][r] = pat_word(w, r);
    rr_m = 1'b0; pend_m = 1'b0; starve_m = 0; last_sel_m = '0;
    pend0 = '0; pend1 = '0;

    forever begin
      @(negedge clk);
      if (started) begin
        if (rst) begin
          chk("m_rst_rd_ready", rd_ready, 0);
          chk("m_rst_wb0_ready", wb0_ready, 0);
          chk("m_rst_wb1_ready", wb1_ready, 0);
          chk("m_rst_read_en0", rf_read_en_0, 0);
          chk("m_rst_read_en1", rf_read_en_1, 0);
          chk("m_rst_write_en", rf_write_en, 0);
          chk("m_rst_rsp_valid", rsp_valid, 0);
          chk("m_rst_sel", rf_warp_selector, last_sel_m);
          rr_m = 1'b0; starve_m = 0; last_sel_m = '0; pend_m = 1'b0;
        end else begin
          chk("m_rsp_valid", rsp_valid, pend_m);
          if (pend_m) begin
            chk("m_rsp_data0", rsp_data0, pend0);
            chk("m_rsp_data1", rsp_data1, pend1);
          end
          have0 = wb0_valid; have1 = wb1_valid;
          hw = have0 || have1;
          ws = (have0 && have1) ? rr_m : have1;
          ww = ws ? wb1_warp : wb0_warp;
          wa = ws ? wb1_addr : wb0_addr;
          wm = ws ? wb1_mask : wb0_mask;
          wd = ws ? wb1_data : wb0_data;
          rg = 1'b0; wg = 1'b0;
          if (rd_valid && !hw) rg = 1'b1;
          else if (!rd_valid && hw) wg = 1'b1;
          else if (rd_valid && hw) begin
            if (rd_warp == ww) begin rg = 1'b1; wg = 1'b1; end
            else if (starve_m >= STARVE_LIMIT) rg = 1'b1;
            else wg = 1'b1;
          end
          esel = rg ? rd_warp : (wg ? ww : last_sel_m);

          chk("m_rd_ready", rd_ready, rg);
          chk("m_wb0_ready", wb0_ready, wg && !ws);
          chk("m_wb1_ready", wb1_ready, wg && ws);
          chk("m_sel", rf_warp_selector, esel);
          chk("m_read_en0", rf_read_en_0, rg ? rd_mask : '0);
          chk("m_read_en1", rf_read_en_1, rg ? rd_mask : '0);
          chk("m_write_en", rf_write_en, wg ? wm : '0);
          if (rg) begin
            chk("m_raddr0", rf_raddr_0, rd_addr0);
            chk("m_raddr1", rf_raddr_1, rd_addr1);
          end
          if (wg) begin
            chk("m_waddr", rf_waddr, wa);
            chk("m_wdata", rf_wdata, wd);
          end

          if (wg) begin
            rr_m = !ws;
            for (int i = 0; i < NUM_LANES; i++)
              if (wm[i]) ref_mem[ww][wa][i*DATA_WIDTH +: DATA_WIDTH] = wd[i*DATA_WIDTH +: DATA_WIDTH];
          end
          if (!rd_valid || rg) starve_m = 0;
          else if (starve_m < STARVE_LIMIT) starve_m++;
          pend_m = rg;
          if (rg) begin
            cur0 = ref_mem[rd_warp][rd_addr0];
            cur1 = ref_mem[rd_warp][rd_addr1];
            for (int i = 0; i < NUM_LANES; i++) begin
              pend0[i*DATA_WIDTH +: DATA_WIDTH] = rd_mask[i] ? cur0[i*DATA_WIDTH +: DATA_WIDTH] : '0;
              pend1[i*DATA_WIDTH +: DATA_WIDTH] = rd_mask[i] ? cur1[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
          end
          last_sel_m = esel;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_valid = 0; rd_warp = '0; rd_addr0 = '0; rd_addr1 = '0; rd_mask = '0;
    wb0_valid = 0; wb0_warp = '0; wb0_addr = '0; wb0_mask = '0; wb0_data = '0;
    wb1_valid = 0; wb1_warp = '0; wb1_addr = '0; wb1_mask = '0; wb1_data = '0;
  endtask

  initial begin : p_stim
    logic [DW-1:0] e0, e1;
    bit g0, g1;

    rst = 1'b1;
    idle();
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rd_ready", rd_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sel", rf_warp_selector, 0);
    chk("reset_rsp_data0", rsp_data0, 0);
    step();

    // Single write, then read it back.
    wb0_valid = 1; wb0_warp = 3; wb0_addr = 5; wb0_mask = 8'hFF;
    for (int i = 0; i < NUM_LANES; i++) wb0_data[i*DATA_WIDTH +: DATA_WIDTH] = 32'hA0 + 32'(i);
    @(negedge clk);
    chk("wr_wb0_ready", wb0_ready, 1);
    chk("wr_sel", rf_warp_selector, 3);
    chk("wr_write_en", rf_write_en, 8'hFF);
    chk("wr_waddr", rf_waddr, 5);
    step();
    idle();
    rd_valid = 1; rd_warp = 3; rd_addr0 = 5; rd_addr1 = 5; rd_mask = 8'hFF;
    @(negedge clk);
    chk("wr_rd_ready", rd_ready, 1);
    step();
    idle();
    @(negedge clk);
    for (int i = 0; i < NUM_LANES; i++) e0[i*DATA_WIDTH +: DATA_WIDTH] = 32'hA0 + 32'(i);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_data0", rsp_data0, e0);
    step();

    // Round-robin from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    wb0_valid = 1; wb0_warp = 1; wb0_addr = 2; wb0_mask = 8'hFF; wb0_data = rand_dw();
    wb1_valid = 1; wb1_warp = 2; wb1_addr = 3; wb1_mask = 8'hF0; wb1_data = rand_dw();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_wb0_ready", wb0_ready, (k % 2) == 0);
      chk("rr_wb1_ready", wb1_ready, (k % 2) == 1);
      step();
    end

    // Same-warp bypass.
    idle();
    wb0_valid = 1; wb0_warp = 2; wb0_addr = 7; wb0_mask = 8'hFF; wb0_data = {8{32'h11}};
    @(negedge clk);
    step();
    idle();
    rd_valid = 1; rd_warp = 2; rd_addr0 = 7; rd_addr1 = 7; rd_mask = 8'hFF;
    wb0_valid = 1; wb0_warp = 2; wb0_addr = 7; wb0_mask = 8'h0F; wb0_data = {8{32'h22}};
    @(negedge clk);
    chk("byp_rd_ready", rd_ready, 1);
    chk("byp_wb0_ready", wb0_ready, 1);
    step();
    idle();
    @(negedge clk);
    e0 = {{4{32'h11}}, {4{32'h22}}};
    chk("byp_rsp_valid", rsp_valid, 1);
    chk("byp_rsp_data0", rsp_data0, e0);
    chk("byp_rsp_data1", rsp_data1, e0);
    step();

    // Starvation: read of warp 1 against continuous writes to warp 4.
    for (int k = 0; k < 6; k++) begin
      rd_valid = (k < 5); rd_warp = 1; rd_addr0 = 4; rd_addr1 = 6; rd_mask = 8'hFF;
      wb0_valid = 1; wb0_warp = 4; wb0_addr = 1; wb0_mask = 8'hFF; wb0_data = rand_dw();
      @(negedge clk);
      if (k < 4) begin
        chk("stv_wb0_ready", wb0_ready, 1);
        chk("stv_rd_ready", rd_ready, 0);
      end else if (k == 4) begin
        chk("stv_rd_forced", rd_ready, 1);
        chk("stv_wb0_blocked", wb0_ready, 0);
        chk("stv_sel", rf_warp_selector, 1);
      end else begin
        chk("stv_rsp_valid", rsp_valid, 1);
      end
      step();
    end

    // Lane masking.
    idle();
    rd_valid = 1; rd_warp = 5; rd_addr0 = 9; rd_addr1 = 10; rd_mask = 8'h81;
    @(negedge clk);
    step();
    idle();
    @(negedge clk);
    e0 = '0; e1 = '0;
    e0[31:0] = 32'h5A050900; e0[255:224] = 32'h5A050907;
    e1[31:0] = 32'h5A050A00; e1[255:224] = 32'h5A050A07;
    chk("mask_rsp_valid", rsp_valid, 1);
    chk("mask_rsp_data0", rsp_data0, e0);
    chk("mask_rsp_data1", rsp_data1, e1);
    step();

    // Reset in the cycle after a read grant.
    rd_valid = 1; rd_warp = 0; rd_addr0 = 1; rd_addr1 = 2; rd_mask = 8'hFF;
    @(negedge clk);
    step();
    rst = 1'b1;
    wb0_valid = 1; wb0_warp = 1; wb0_addr = 3; wb0_mask = 8'hFF; wb0_data = rand_dw();
    wb1_valid = 1; wb1_warp = 2; wb1_addr = 4; wb1_mask = 8'hFF; wb1_data = rand_dw();
    @(negedge clk);
    chk("rmid_rsp_valid", rsp_valid, 0);
    chk("rmid_rd_ready", rd_ready, 0);
    chk("rmid_wb0_ready", wb0_ready, 0);
    chk("rmid_wb1_ready", wb1_ready, 0);
    chk("rmid_write_en", rf_write_en, 0);
    chk("rmid_read_en0", rf_read_en_0, 0);
    step();
    @(negedge clk);
    step();
    rst = 1'b0;
    rd_valid = 0;
    @(negedge clk);
    chk("rmid_first_wb0", wb0_ready, 1);
    chk("rmid_first_wb1", wb1_ready, 0);
    step();

    // Randomized traffic; a losing writeback holds its request.
    g0 = 1'b1; g1 = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      rd_valid = ($urandom_range(0, 9) < 6);
      rd_warp  = WW'($urandom_range(0, 3));
      rd_addr0 = AW'($urandom_range(0, 3));
      rd_addr1 = AW'($urandom_range(0, 3));
      rd_mask  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if (!(wb0_valid && !g0)) begin
        wb0_valid = ($urandom_range(0, 9) < 6);
        wb0_warp  = WW'($urandom_range(0, 3));
        wb0_addr  = AW'($urandom_range(0, 3));
        wb0_mask  = 8'($urandom);
        wb0_data  = rand_dw();
      end
      if (!(wb1_valid && !g1)) begin
        wb1_valid = ($urandom_range(0, 9) < 6);
        wb1_warp  = WW'($urandom_range(0, 3));
        wb1_addr  = AW'($urandom_range(0, 3));
        wb1_mask  = 8'($urandom);
        wb1_data  = rand_dw();
      end
      @(negedge clk);
      g0 = wb0_ready;
      g1 = wb1_ready;
      step();
    end

    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_access_scheduler.md
# rf_access_scheduler

Per-cycle access scheduler for the banked `register_block` (NUM_LANES lanes, two read ports, one write port, one shared `warp_selector`). It merges one operand-read requester (issue stage) and two writeback requesters (ALU, LSU) onto the register block's ports. Because `warp_selector` is shared by reads and writes, a read and a write can only go in the same cycle when they target the same warp. The block also returns registered operand data, with same-cycle write bypass.

## Interface
- `NUM_LANES`, 8, lanes per warp.
- `NUM_WARPS`, 8, warps; `WW = $clog2(NUM_WARPS)`.
- `NUM_REGS`, 32, registers per lane; `AW = $clog2(NUM_REGS)`.
- `DATA_WIDTH`, 32, register width; `DW = NUM_LANES*DATA_WIDTH`.
- `STARVE_LIMIT`, 4, consecutive write-blocked cycles before a read is forced.

Ports:
- `clk`  in  1  clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rd_valid` / `rd_ready`  in / out  1  operand-read handshake.
- `rd_warp`  in  WW  warp for the read.
- `rd_addr0`, `rd_addr1`  in  AW  source registers.
- `rd_mask`  in  NUM_LANES  active lanes for the read.
- `wbN_valid` / `wbN_ready` (N=0,1)  in / out  1  writeback handshake.
- `wbN_warp`  in  WW  target warp.
- `wbN_addr`  in  AW  destination register.
- `wbN_mask`  in  NUM_LANES  lanes to write.
- `wbN_data`  in  DW  lane i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rf_warp_selector`  out  WW  to `warp_selector`.
- `rf_read_en_0`, `rf_read_en_1`  out  NUM_LANES  per-lane read enables.
- `rf_raddr_0`, `rf_raddr_1`  out  AW  read addresses.
- `rf_write_en`  out  NUM_LANES  per-lane write enables.
- `rf_waddr`  out  AW  write address.
- `rf_wdata`  out  DW  write data, flat lane packing; the integration wrapper splits it onto `wdata_0..7`.
- `rf_rdata_0`, `rf_rdata_1`  in  DW  combinational read data from the register block.
- `rsp_valid`  out  1  operand response strobe; no backpressure.
- `rsp_data0`, `rsp_data1`  out  DW  operand data.

## Operation
- **Write candidate W:** round-robin between `wb0` and `wb1`.
  - Pointer `rr` names the preferred source. If only one source is valid, it is chosen.
  - After a write grant, `rr` points to the source that was not granted.
- **Grant rules, evaluated every cycle:**
  - Read only: grant the read.
  - W only: grant W.
  - Both, with `rd_warp == W.warp`: grant both.
  - Both, different warps, `starve_cnt >= STARVE_LIMIT`: grant the read only.
  - Both, different warps, otherwise: grant W only, and `starve_cnt` increments (saturating).
  - `starve_cnt` clears on any read grant, and in any cycle where `rd_valid` is 0.
- **Ready outputs:** `rd_ready` and `wbN_ready` equal their grants.
  - They are combinational from the valids and state.
  - The losing wb source sees ready 0 and must hold its request stable.
- **Register block drive:**
  - `rf_warp_selector`: the read warp if a read is granted, else the write warp if a write is granted, else the last driven value.
  - Read grant: `rf_read_en_0 = rf_read_en_1 = rd_mask`, `rf_raddr_0/1 = rd_addr0/1`.
  - Write grant: `rf_write_en = W.mask`; `rf_waddr` and `rf_wdata` come from W.
  - All enables are 0 when the corresponding port is not granted.
- **Response capture:** on a read grant, capture `rf_rdata_0/1` per lane at the cycle end.
  - Lanes not in `rd_mask` return 0.
- **Bypass:** when read and write are granted together, `rf_raddrK == rf_waddr`, and lane i is in both masks, then lane i of `rsp_dataK` is W's data instead of the old register value.
- **Reset:** while `rst` is high, all readies and enables are forced to 0. Reset values:
  - `rsp_valid` 0
  - `rsp_data0/1` 0
  - `rr` = wb0
  - `starve_cnt` 0
  - `rf_warp_selector` 0

## Timing
- Grant decision is zero latency: request and grant happen in the same cycle, and the register block is driven in that cycle.
- Write commits at the next `clk` edge.
- `rsp_valid` pulses exactly one cycle after each read grant. Back-to-back read grants give a `rsp_valid` pulse every cycle.
- A read blocked by writes to other warps is granted within STARVE_LIMIT+1 cycles of its first valid cycle.
- Reset asserted in the cycle after a read grant: `rsp_valid` stays 0, i.e. the in-flight response is dropped. `rr` and `starve_cnt` reinitialise on the same edge.
- Hazards between a read and a writeback that is not granted in the same cycle belong to the scoreboard; this block only guarantees same-cycle bypass.

## Test plan
- **Single write:** `wb0` valid, warp 3, addr 5, mask 0xFF, data lanes `0xA0+i`, one cycle. Required: `wb0_ready` 1, `rf_warp_selector` 3, `rf_write_en` 0xFF, `rf_waddr` 5. A read of warp 3 addr 5 one cycle later returns lanes `0xA0+i`.
- **Round-robin:** `wb0` and `wb1` valid for 6 cycles (warps 1 and 2), no read. Required grants: wb0, wb1, wb0, wb1, wb0, wb1.
- **Same-warp bypass:** warp 2 addr 7 pre-loaded with 0x11 in all lanes. Then in one cycle: read warp 2 addr0=7, addr1=7, mask 0xFF; `wb0` writes warp 2 addr 7, mask 0x0F, data 0x22. Required: both granted; next cycle `rsp_valid` 1, lanes 0-3 = 0x22 and lanes 4-7 = 0x11 on both ports.
- **Starvation:** read warp 1 held valid; `wb0` continuously valid for warp 4. Required: `wb0` granted for cycles 0-3; read granted in cycle 4 with `rf_warp_selector` 1 and `wb0_ready` 0; `rsp_valid` in cycle 5.
- **Lane masking:** read with mask 0x81. Required: response lanes 1-6 are 0; lanes 0 and 7 carry register data.
- **Reset mid-operation:** assert `rst` in the cycle after a read grant, with both wb sources valid. Required: `rsp_valid` 0, all readies and enables 0 while `rst` is high. The first grant after release goes to wb0.
